// File: rtl/case_1_mul_acc_pipe.sv
// case_1_mul_acc_pipe: pipelined signed multiply with saturating accumulate and valid/ready handshake
module case_1_mul_acc_pipe #(
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 16,
  parameter int NUM_STAGE  = 3
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         acc_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);
  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam logic signed [dout_WIDTH-1:0] MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [dout_WIDTH-1:0] MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};
  logic [NUM_STAGE-1:0] s_valid, s_acc;
  logic signed [dout_WIDTH-1:0] s_prod [NUM_STAGE];
  logic signed [dout_WIDTH-1:0] acc, res;
  logic signed [PW-1:0] prod;
  logic signed [dout_WIDTH:0] sum;
  logic sat_hi, sat_lo;
  assign in_ready = ap_rst_n && ce && !(out_valid && !out_ready);
  assign prod = PW'(din0) * PW'(din1);
  assign sum = (dout_WIDTH+1)'(acc) + (dout_WIDTH+1)'(s_prod[NUM_STAGE-1]);
  assign sat_hi = !sum[dout_WIDTH] && sum[dout_WIDTH-1];
  assign sat_lo = sum[dout_WIDTH] && !sum[dout_WIDTH-1];
  assign res = !s_acc[NUM_STAGE-1] ? s_prod[NUM_STAGE-1] : sat_hi ? MAX : sat_lo ? MIN : sum[dout_WIDTH-1:0];
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s_valid   <= '0;
      acc       <= '0;
      dout      <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_ready) begin
      for (int i = NUM_STAGE - 1; i > 0; i--) begin
        s_valid[i] <= s_valid[i-1];
        s_acc[i]   <= s_acc[i-1];
        s_prod[i]  <= s_prod[i-1];
      end
      s_valid[0] <= in_valid;
      s_acc[0]   <= acc_en;
      s_prod[0]  <= dout_WIDTH'(prod);
      out_valid  <= s_valid[NUM_STAGE-1];
      if (s_valid[NUM_STAGE-1]) begin
        dout <= res;
        acc  <= res;
        ovf  <= s_acc[NUM_STAGE-1] && (sat_hi || sat_lo);
      end
    end
  end
endmodule

// File: tb/tb_case_1_mul_acc_pipe.sv
// tb_case_1_mul_acc_pipe: directed vectors with hand-computed results for the MAC pipeline
module tb_case_1_mul_acc_pipe;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, ce = 1'b1, in_valid = 1'b0, acc_en = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, ovf;
  logic signed [7:0] din0 = '0;
  logic signed [6:0] din1 = '0;
  logic signed [15:0] dout, hd;
  logic ho;
  int n_vec, n_err, cyc_n;
  bit lat_on, bp_on, hv;
  int q_d[$], q_o[$], q_t[$];
  int bp_exp[10] = '{2, 8, 20, 40, 70, 112, 168, 240, 330, 440};
  case_1_mul_acc_pipe dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .ovf(ovf)
  );
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) begin
    cyc_n++;
    #1 out_ready = bp_on ? (cyc_n % 4 == 0 || cyc_n % 4 == 3) : 1'b1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic send(input int a, input int b, input bit en, input int ed, input bit eo, input bit keep);
    int n = 0;
    bit ok;
    in_valid = 1'b1;
    din0 = 8'(a);
    din1 = 7'(b);
    acc_en = en;
    do begin
      @(negedge ap_clk) ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("accept_timeout", 0, 1);
    else if (keep) begin
      q_d.push_back(ed);
      q_o.push_back(int'(eo));
      q_t.push_back(cyc_n);
    end
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q_d.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", q_d.size(), 0);
    repeat (2) tick();
  endtask
  always @(negedge ap_clk) begin
    if (hv) begin
      chk("hold_dout", dout, hd);
      chk("hold_ovf", ovf, ho);
      chk("hold_valid", out_valid, 1);
    end
    hv = ap_rst_n && out_valid && (!out_ready || !ce);
    hd = dout;
    ho = ovf;
    if (ap_rst_n) chk("in_ready", in_ready, ce && !(out_valid && !out_ready));
    if (ap_rst_n && ce && out_valid && out_ready) begin
      if (q_d.size() == 0) chk("extra_out", 1, 0);
      else begin
        chk("dout", dout, q_d[0]);
        chk("ovf", ovf, q_o[0]);
        if (lat_on) chk("latency", cyc_n - q_t[0], 3);
        void'(q_d.pop_front());
        void'(q_o.pop_front());
        void'(q_t.pop_front());
      end
    end
  end
  initial begin
    repeat (2) tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
    ap_rst_n = 1'b1;
    lat_on = 1'b1;
    send(3, 5, 0, 15, 0, 1);
    send(-128, -64, 0, 8192, 0, 1);
    send(127, -64, 0, -8128, 0, 1);
    send(10, 10, 0, 100, 0, 1);
    send(-7, 3, 1, 79, 0, 1);
    send(2, 2, 1, 83, 0, 1);
    send(-128, -64, 0, 8192, 0, 1);
    send(-128, -64, 1, 16384, 0, 1);
    send(-128, -64, 1, 24576, 0, 1);
    send(-128, -64, 1, 32767, 1, 1);
    send(-1, 1, 1, 32766, 0, 1);
    send(-128, 63, 0, -8064, 0, 1);
    send(-128, 63, 1, -16128, 0, 1);
    send(-128, 63, 1, -24192, 0, 1);
    send(-128, 63, 1, -32256, 0, 1);
    send(-128, 63, 1, -32768, 1, 1);
    send(1, 1, 1, -32767, 0, 1);
    drain();
    lat_on = 1'b0;
    bp_on = 1'b1;
    for (int i = 0; i < 10; i++) send(i + 1, i + 2, i != 0, bp_exp[i], 0, 1);
    drain();
    bp_on = 1'b0;
    tick();
    send(5, 5, 0, 25, 0, 1);
    send(3, 3, 1, 34, 0, 1);
    din0 = 8'sd2;
    din1 = 7'sd2;
    ce = 1'b0;
    repeat (4) begin
      tick();
      chk("ce_valid", out_valid, 0);
      chk("ce_dout", dout, 440);
      chk("ce_acc", dut.acc, 440);
    end
    ce = 1'b1;
    send(2, 2, 1, 38, 0, 1);
    drain();
    send(7, 7, 0, 0, 0, 0);
    send(1, 1, 1, 0, 0, 0);
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_acc", dut.acc, 0);
    chk("mid_rst_ovf", ovf, 0);
    ap_rst_n = 1'b1;
    repeat (5) tick();
    chk("flush_valid", out_valid, 0);
    send(4, 4, 1, 16, 0, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
